// File: rtl/shift_pkg.sv
// Shared definitions for the serial link: bit-order constants, the collector
// state encoding and a parameter sanity check.
package shift_pkg;

  // Bit-order selector values. These are shared with the shift_reg serializer.
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Collector states: IDLE means no partial word, COLLECT means 1..WIDTH-1 bits held.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // True when a word width can be handled by the link (2..32 bits).
  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

endpackage

// File: rtl/shift_deser_if.sv
// Bundle of the serial-input and parallel-output signals of the deserializer.
// The slave modport is the deserializer's view. The master modport is the
// view of whoever drives the line and consumes the words.
interface shift_deser_if #(
  parameter int WIDTH = 4
);
  logic             s_in;
  logic             s_valid;
  logic             shift_dir;
  logic             clear;
  logic [WIDTH-1:0] D_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport slave (
    input  s_in,
    input  s_valid,
    input  shift_dir,
    input  clear,
    input  out_ready,
    output D_out,
    output out_valid,
    output busy,
    output overrun
  );

  modport master (
    output s_in,
    output s_valid,
    output shift_dir,
    output clear,
    output out_ready,
    input  D_out,
    input  out_valid,
    input  busy,
    input  overrun
  );
endinterface

// File: rtl/shift_deser_core.sv
// Bit collector: shifts accepted serial bits into shreg and counts them. It
// latches the bit order on the first bit of each word. It raises a
// combinational done strobe, with the assembled word, when the last bit arrives.
module shift_deser_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             shift_dir,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dir_lat_q, dir_lat_d;

  logic             accept;
  logic             dir_cur;
  logic [WIDTH-1:0] shl_word;
  logic [WIDTH-1:0] shr_word;

  // A bit counts only when it is not flushed away by clear in the same cycle.
  assign accept = s_valid & ~clear;

  // The first bit of a word follows shift_dir directly. Later bits use the latched order.
  assign dir_cur = (state_q == ST_IDLE) ? shift_dir : dir_lat_q;

  // Candidate next contents of shreg for both bit orders.
  // The new bit enters at the LSB for MSB-first and at the MSB for LSB-first.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_shl_lsb
        assign shl_word[gi] = s_in;
      end else begin : g_shl_mid
        assign shl_word[gi] = shreg_q[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_shr_msb
        assign shr_word[gi] = s_in;
      end else begin : g_shr_mid
        assign shr_word[gi] = shreg_q[gi+1];
      end
    end
  endgenerate

  assign word = (dir_cur == DIR_LSB_FIRST) ? shr_word : shl_word;
  assign done = accept && (bit_cnt_q == LAST);
  assign busy = (bit_cnt_q != '0);

  // State, shift register, bit counter and direction latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dir_lat_q <= DIR_MSB_FIRST;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      dir_lat_q <= dir_lat_d;
    end
  end

  // Next state: clear flushes the partial word. Otherwise an accepted bit
  // shifts in and advances the count, wrapping to IDLE on the last bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    dir_lat_d = dir_lat_q;
    if (clear) begin
      state_d   = ST_IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (s_valid) begin
      shreg_d = word;
      if (state_q == ST_IDLE) begin
        dir_lat_d = shift_dir;
      end
      if (bit_cnt_q == LAST) begin
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        state_d   = ST_COLLECT;
      end
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-in, parallel-out receiver. The core assembles words. This level holds
// the output register and the valid/ready handshake. It flags overrun when a
// finished word arrives while the consumer is still stalled.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  shift_deser_if.slave  bus
);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("shift_deser: WIDTH must be in 2..32");
    end
  endgenerate

  logic [WIDTH-1:0] word;
  logic             done;
  logic             core_busy;

  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             take;
  logic             drop;

  shift_deser_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_in      (bus.s_in),
    .s_valid   (bus.s_valid),
    .shift_dir (bus.shift_dir),
    .clear     (bus.clear),
    .word      (word),
    .done      (done),
    .busy      (core_busy)
  );

  // A finished word is kept if the holding register is empty or is being read
  // this cycle. Otherwise the word is lost.
  assign take = done & (~out_valid_q | bus.out_ready);
  assign drop = done & out_valid_q & ~bus.out_ready;

  // Output holding register, valid flag and overrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      d_out_q     <= d_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Handshake: a read empties the register unless a new word lands in the same cycle.
  always_comb begin
    d_out_d     = d_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (take) begin
      d_out_d     = word;
      out_valid_d = 1'b1;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  assign bus.D_out     = d_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = core_busy;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser with WIDTH=4. Each task drives one scenario
// and checks hand-computed values inline.
module tb_shift_deser;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  shift_deser_if #(.WIDTH(4)) bus ();

  shift_deser #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.s_in    = b;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.s_in    = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    compared++;
    if (bus.D_out !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_dout: got %b required 0000", bus.D_out);
    end
    compared++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got valid=%b busy=%b ovr=%b required 0 0 0",
               bus.out_valid, bus.busy, bus.overrun);
    end
    reset_n = 1'b1;
    $display("reset: D_out=%b out_valid=%b", bus.D_out, bus.out_valid);
  endtask

  task automatic test_reset_midword();
    bus.out_ready = 1'b0;
    bus.shift_dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    compared++;
    if (bus.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midword_busy: got %b required 1", bus.busy);
    end
    reset_n = 1'b0;
    #2;
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_busy: got %b required 0", bus.busy);
    end
    tick();
    reset_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_word_early: got valid=%b required 0", bus.out_valid);
    end
    send_bit(1'b0);
    compared++;
    if (bus.D_out !== 4'b1010 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_word: got %b valid=%b required 1010 valid=1", bus.D_out, bus.out_valid);
    end
    $display("reset mid-word: D_out=%b", bus.D_out);
  endtask

  task automatic test_msb_first();
    bus.out_ready = 1'b1;
    tick();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_valid: got %b required 0", bus.out_valid);
    end
    bus.shift_dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    compared++;
    if (bus.D_out !== 4'b1110 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL msb_word: got %b valid=%b required 1110 valid=1", bus.D_out, bus.out_valid);
    end
    tick();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.D_out !== 4'b1110) begin
      mismatched++;
      $display("FAIL msb_valid_pulse: got valid=%b D_out=%b required valid=0 D_out=1110",
               bus.out_valid, bus.D_out);
    end
    $display("msb-first: D_out=%b", bus.D_out);
  endtask

  task automatic test_lsb_gaps();
    logic [3:0] bits;
    bits = 4'b0010;
    bus.out_ready = 1'b1;
    bus.shift_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i]);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          compared++;
          if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL lsb_busy_gap%0d_%0d: got %b required 1", i, g, bus.busy);
          end
          tick();
        end
      end
    end
    compared++;
    if (bus.D_out !== 4'b0010 || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL lsb_word: got %b valid=%b busy=%b required 0010 valid=1 busy=0",
               bus.D_out, bus.out_valid, bus.busy);
    end
    tick();
    $display("lsb-first with gaps: D_out=%b", bus.D_out);
  endtask

  task automatic test_dir_latch();
    bus.out_ready = 1'b1;
    bus.shift_dir = 1'b0;
    send_bit(1'b1);
    bus.shift_dir = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    compared++;
    if (bus.D_out !== 4'b1100 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL dir_latch_word: got %b valid=%b required 1100 valid=1", bus.D_out, bus.out_valid);
    end
    bus.shift_dir = 1'b0;
    tick();
    $display("direction latch: D_out=%b", bus.D_out);
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    bus.shift_dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    compared++;
    if (bus.D_out !== 4'b1110 || bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_first: got %b valid=%b ovr=%b required 1110 1 0",
               bus.D_out, bus.out_valid, bus.overrun);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    compared++;
    if (bus.overrun !== 1'b1 || bus.D_out !== 4'b1110 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_drop: got ovr=%b D_out=%b valid=%b required 1 1110 1",
               bus.overrun, bus.D_out, bus.out_valid);
    end
    tick();
    compared++;
    if (bus.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_pulse_len: got %b required 0", bus.overrun);
    end
    bus.out_ready = 1'b1;
    tick();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.D_out !== 4'b1110) begin
      mismatched++;
      $display("FAIL ovr_drain: got valid=%b D_out=%b required 0 1110", bus.out_valid, bus.D_out);
    end
    $display("overrun: D_out=%b", bus.D_out);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.shift_dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    compared++;
    if (bus.D_out !== 4'b0001 || bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_word: got %b valid=%b ovr=%b required 0001 1 0",
               bus.D_out, bus.out_valid, bus.overrun);
    end
    bus.out_ready = 1'b0;
    tick();
    compared++;
    if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_after: got ovr=%b valid=%b required 0 1", bus.overrun, bus.out_valid);
    end
    $display("back-to-back: D_out=%b", bus.D_out);
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b1;
    bus.shift_dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.clear = 1'b1;
    send_bit(1'b0);
    bus.clear = 1'b0;
    compared++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_priority: got busy=%b valid=%b required 0 0", bus.busy, bus.out_valid);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    compared++;
    if (bus.D_out !== 4'b0101 || bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL clear_next_word: got %b valid=%b required 0101 1", bus.D_out, bus.out_valid);
    end
    $display("clear: D_out=%b", bus.D_out);
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset_n       = 1'b0;
    bus.s_in      = 1'b0;
    bus.s_valid   = 1'b0;
    bus.shift_dir = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_reset_midword();
    test_msb_first();
    test_lsb_gaps();
    test_dir_latch();
    test_overrun();
    test_back_to_back();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
